// File: rtl/apb_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Optional ACCESS-phase timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        r0_req_vld,
    output logic        r0_req_rdy,
    input  logic [31:0] r0_req_addr,
    input  logic [31:0] r0_req_wdata,
    input  logic        r0_req_write,
    output logic        r0_rsp_vld,
    output logic [31:0] r0_rsp_rdata,
    output logic        r0_rsp_err,

    input  logic        r1_req_vld,
    output logic        r1_req_rdy,
    input  logic [31:0] r1_req_addr,
    input  logic [31:0] r1_req_wdata,
    input  logic        r1_req_write,
    output logic        r1_rsp_vld,
    output logic [31:0] r1_rsp_rdata,
    output logic        r1_rsp_err,

    output logic [31:0] m_paddr,
    output logic [31:0] m_pwdata,
    output logic        m_pwrite,
    output logic        m_psel,
    output logic        m_penable,
    input  logic [31:0] m_prdata,
    input  logic        m_pready,
    input  logic        m_pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    // The timeout compare needs at least two ACCESS cycles to be meaningful.
    if (TIMEOUT_CYCLES < 2) begin : g_param_chk
        $error("apb_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        r0_vld_q, r0_vld_d;
    logic        r1_vld_q, r1_vld_d;
    logic [31:0] r0_rdata_q, r0_rdata_d;
    logic [31:0] r1_rdata_q, r1_rdata_d;
    logic        r0_err_q, r0_err_d;
    logic        r1_err_q, r1_err_d;

    logic        grant_s;
    logic        hs_s;
    logic        timeout_s;
    logic        done_s;
    logic [31:0] rsp_rdata_s;
    logic        rsp_err_s;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ACCESS-cycle counter: cleared on the way into ACCESS, counts stalled cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = {CNT_W{1'b0}};
        end else if ((state_q == ACCESS) && !m_pready) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_s = (state_q == ACCESS) && !m_pready &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Round-robin grant: on a tie the requester not granted last wins.
    always_comb begin
        grant_s = 1'b0;
        if (r0_req_vld && r1_req_vld) begin
            grant_s = ~last_q;
        end else if (r1_req_vld) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign hs_s       = (state_q == IDLE) && (r0_req_vld || r1_req_vld);
    assign r0_req_rdy = hs_s && r0_req_vld && !grant_s;
    assign r1_req_rdy = hs_s && r1_req_vld && grant_s;

    assign done_s      = (state_q == ACCESS) && (m_pready || timeout_s);
    assign rsp_rdata_s = (m_pready && !write_q) ? m_prdata : 32'h0000_0000;
    assign rsp_err_s   = m_pready ? m_pslverr : 1'b1;

    // Next-state and APB phase control.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        case (state_q)
            IDLE: begin
                if (hs_s) begin
                    state_d   = SETUP;
                    last_d    = grant_s;
                    owner_d   = grant_s;
                    addr_d    = grant_s ? r1_req_addr  : r0_req_addr;
                    wdata_d   = grant_s ? r1_req_wdata : r0_req_wdata;
                    write_d   = grant_s ? r1_req_write : r0_req_write;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end else begin
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (done_s) begin
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end else begin
                    state_d   = ACCESS;
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // Completion response steered to the owner; the other side stays all-zero.
    always_comb begin
        r0_vld_d   = 1'b0;
        r1_vld_d   = 1'b0;
        r0_rdata_d = 32'h0000_0000;
        r1_rdata_d = 32'h0000_0000;
        r0_err_d   = 1'b0;
        r1_err_d   = 1'b0;
        if (done_s) begin
            if (owner_q) begin
                r1_vld_d   = 1'b1;
                r1_rdata_d = rsp_rdata_s;
                r1_err_d   = rsp_err_s;
            end else begin
                r0_vld_d   = 1'b1;
                r0_rdata_d = rsp_rdata_s;
                r0_err_d   = rsp_err_s;
            end
        end else begin
            r0_vld_d = 1'b0;
            r1_vld_d = 1'b0;
        end
    end

    // State, captured transfer and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            write_q    <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            r0_vld_q   <= 1'b0;
            r1_vld_q   <= 1'b0;
            r0_rdata_q <= 32'h0000_0000;
            r1_rdata_q <= 32'h0000_0000;
            r0_err_q   <= 1'b0;
            r1_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            r0_vld_q   <= r0_vld_d;
            r1_vld_q   <= r1_vld_d;
            r0_rdata_q <= r0_rdata_d;
            r1_rdata_q <= r1_rdata_d;
            r0_err_q   <= r0_err_d;
            r1_err_q   <= r1_err_d;
        end
    end

    assign m_paddr      = addr_q;
    assign m_pwdata     = wdata_q;
    assign m_pwrite     = write_q;
    assign m_psel       = psel_q;
    assign m_penable    = penable_q;
    assign r0_rsp_vld   = r0_vld_q;
    assign r1_rsp_vld   = r1_vld_q;
    assign r0_rsp_rdata = r0_rdata_q;
    assign r1_rsp_rdata = r1_rdata_q;
    assign r0_rsp_err   = r0_err_q;
    assign r1_rsp_err   = r1_err_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: table of single transfers plus hand sequences.
module tb_apb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req_vld = 1'b0, r1_req_vld = 1'b0;
    logic        r0_req_rdy, r1_req_rdy;
    logic [31:0] r0_req_addr = 32'h0, r1_req_addr = 32'h0;
    logic [31:0] r0_req_wdata = 32'h0, r1_req_wdata = 32'h0;
    logic        r0_req_write = 1'b0, r1_req_write = 1'b0;
    logic        r0_rsp_vld, r1_rsp_vld;
    logic [31:0] r0_rsp_rdata, r1_rsp_rdata;
    logic        r0_rsp_err, r1_rsp_err;
    logic [31:0] m_paddr, m_pwdata;
    logic        m_pwrite, m_psel, m_penable;
    logic [31:0] m_prdata = 32'h0;
    logic        m_pready = 1'b0;
    logic        m_pslverr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    apb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .r0_req_vld(r0_req_vld), .r0_req_rdy(r0_req_rdy), .r0_req_addr(r0_req_addr),
        .r0_req_wdata(r0_req_wdata), .r0_req_write(r0_req_write),
        .r0_rsp_vld(r0_rsp_vld), .r0_rsp_rdata(r0_rsp_rdata), .r0_rsp_err(r0_rsp_err),
        .r1_req_vld(r1_req_vld), .r1_req_rdy(r1_req_rdy), .r1_req_addr(r1_req_addr),
        .r1_req_wdata(r1_req_wdata), .r1_req_write(r1_req_write),
        .r1_rsp_vld(r1_rsp_vld), .r1_rsp_rdata(r1_rsp_rdata), .r1_rsp_err(r1_rsp_err),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite),
        .m_psel(m_psel), .m_penable(m_penable),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v0, v1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        int          wait_n;
        logic [31:0] prdata;
        logic        slverr;
        logic        exp_owner;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer; entered with the DUT idle, #1 after a rising edge.
    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] ea, ed;
        logic        ew;
        ea = v.exp_owner ? v.a1 : v.a0;
        ed = v.exp_owner ? v.d1 : v.d0;
        ew = v.exp_owner ? v.w1 : v.w0;
        r0_req_vld = v.v0; r0_req_addr = v.a0; r0_req_wdata = v.d0; r0_req_write = v.w0;
        r1_req_vld = v.v1; r1_req_addr = v.a1; r1_req_wdata = v.d1; r1_req_write = v.w1;
        #1;
        chk("r0_rdy", idx, {31'd0, r0_req_rdy}, {31'd0, ~v.exp_owner});
        chk("r1_rdy", idx, {31'd0, r1_req_rdy}, {31'd0, v.exp_owner});
        tick();
        r0_req_vld = 1'b0;
        r1_req_vld = 1'b0;
        chk("setup_sel_en", idx, {30'd0, m_psel, m_penable}, 32'd2);
        chk("paddr", idx, m_paddr, ea);
        chk("pwdata", idx, m_pwdata, ed);
        chk("pwrite", idx, {31'd0, m_pwrite}, {31'd0, ew});
        tick();
        chk("access_sel_en", idx, {30'd0, m_psel, m_penable}, 32'd3);
        for (int k = 0; k < v.wait_n; k++) begin
            tick();
            chk("wait_sel_en", idx, {30'd0, m_psel, m_penable}, 32'd3);
            chk("wait_paddr", idx, m_paddr, ea);
            chk("wait_pwdata", idx, m_pwdata, ed);
            chk("wait_rsp", idx, {30'd0, r0_rsp_vld, r1_rsp_vld}, 32'd0);
        end
        m_pready = 1'b1; m_prdata = v.prdata; m_pslverr = v.slverr;
        tick();
        m_pready = 1'b0; m_prdata = 32'hA5A5_A5A5; m_pslverr = 1'b1;
        chk("rsp_vld", idx, {30'd0, r0_rsp_vld, r1_rsp_vld}, v.exp_owner ? 32'd1 : 32'd2);
        chk("rsp_rdata", idx, v.exp_owner ? r1_rsp_rdata : r0_rsp_rdata, v.exp_rdata);
        chk("rsp_err", idx, {31'd0, v.exp_owner ? r1_rsp_err : r0_rsp_err}, {31'd0, v.exp_err});
        chk("other_rsp", idx, v.exp_owner ? r0_rsp_rdata : r1_rsp_rdata, 32'd0);
        chk("other_err", idx, {31'd0, v.exp_owner ? r0_rsp_err : r1_rsp_err}, 32'd0);
        chk("idle_sel", idx, {30'd0, m_psel, m_penable}, 32'd0);
        tick();
        m_pslverr = 1'b0;
        chk("rsp_pulse_end", idx, {30'd0, r0_rsp_vld, r1_rsp_vld}, 32'd0);
        chk("rsp_rdata_zero", idx, r0_rsp_rdata | r1_rsp_rdata, 32'd0);
    endtask

    initial begin
        int n;
        // v0 v1 w0 w1 a0 a1 d0 d1 wait prdata slverr | owner rdata err
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hC000_1000, 32'h0, 32'h0, 32'h0,
                    0, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hC000_2004, 32'h0, 32'hDEAD_BEEF,
                    4, 32'hAAAA_5555, 1'b0, 1'b1, 32'h0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0020, 32'h1, 32'h2,
                    0, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0024, 32'h1, 32'h0000_55AA,
                    1, 32'h1111_2222, 1'b1, 1'b1, 32'h0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0000_0040, 32'hCAFE_0001, 32'h3,
                    2, 32'h3333_4444, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0,
                    1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0050, 32'h0000_0060, 32'h0, 32'h0,
                    0, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0001, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 32'h0, 32'h0,
                    0, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0};

        // Reset state.
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_sel_en", 0, {30'd0, m_psel, m_penable}, 32'd0);
        chk("rst_pwrite", 0, {31'd0, m_pwrite}, 32'd0);
        chk("rst_paddr", 0, m_paddr, 32'd0);
        chk("rst_pwdata", 0, m_pwdata, 32'd0);
        chk("rst_rsp", 0, {28'd0, r0_rsp_vld, r1_rsp_vld, r0_rsp_err, r1_rsp_err}, 32'd0);
        chk("rst_rdata", 0, r0_rsp_rdata | r1_rsp_rdata, 32'd0);
        chk("rst_rdy", 0, {30'd0, r0_req_rdy, r1_req_rdy}, 32'd0);

        // Simultaneous requests held out of reset: r0 first, r1 handshakes at T+3.
        r0_req_vld = 1'b1; r0_req_addr = 32'h0000_0100; r0_req_write = 1'b0;
        r1_req_vld = 1'b1; r1_req_addr = 32'h0000_0200; r1_req_write = 1'b1;
        r1_req_wdata = 32'h0000_0003;
        #1;
        chk("tie_rdy", 0, {30'd0, r0_req_rdy, r1_req_rdy}, 32'd2);
        tick();
        chk("setup_rdy", 0, {30'd0, r0_req_rdy, r1_req_rdy}, 32'd0);
        chk("tie_paddr", 0, m_paddr, 32'h0000_0100);
        tick();
        m_pready = 1'b1; m_prdata = 32'h0000_0077;
        chk("access_rdy", 0, {30'd0, r0_req_rdy, r1_req_rdy}, 32'd0);
        tick();
        m_pready = 1'b0;
        chk("tie_rsp0", 0, {30'd0, r0_rsp_vld, r1_rsp_vld}, 32'd2);
        chk("tie_rdata0", 0, r0_rsp_rdata, 32'h0000_0077);
        chk("tie_rdy2", 0, {30'd0, r0_req_rdy, r1_req_rdy}, 32'd1);
        tick();
        r0_req_vld = 1'b0; r1_req_vld = 1'b0;
        chk("tie_paddr1", 0, m_paddr, 32'h0000_0200);
        chk("tie_pwrite1", 0, {31'd0, m_pwrite}, 32'd1);
        tick();
        m_pready = 1'b1;
        tick();
        m_pready = 1'b0;
        chk("tie_rsp1", 0, {30'd0, r0_rsp_vld, r1_rsp_vld}, 32'd1);
        chk("tie_rdata1", 0, r1_rsp_rdata, 32'd0);
        tick();

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset mid-ACCESS aborts; a request dropped outside IDLE leaves no trace.
        r0_req_vld = 1'b1; r0_req_addr = 32'h0000_0ABC; r0_req_write = 1'b0;
        tick();
        r0_req_vld = 1'b0;
        r1_req_vld = 1'b1; r1_req_addr = 32'h0000_0DEF;
        tick();
        r1_req_vld = 1'b0;
        m_pready = 1'b1; m_prdata = 32'h5555_5555;
        rst = 1'b1;
        tick();
        rst = 1'b0; m_pready = 1'b0;
        chk("abort_sel", 0, {30'd0, m_psel, m_penable}, 32'd0);
        chk("abort_rsp", 0, {30'd0, r0_rsp_vld, r1_rsp_vld}, 32'd0);
        chk("abort_paddr", 0, m_paddr, 32'd0);
        tick();
        chk("drop_sel", 0, {30'd0, m_psel, m_penable}, 32'd0);
        chk("drop_rsp", 0, {30'd0, r0_rsp_vld, r1_rsp_vld}, 32'd0);
        r1_req_vld = 1'b1;
        #1;
        chk("late_rdy", 0, {30'd0, r0_req_rdy, r1_req_rdy}, 32'd1);
        r1_req_vld = 1'b0;
        tick();
        chk("late_drop_sel", 0, {31'd0, m_psel}, 32'd0);

`ifdef APB_ARB_TIMEOUT_EN
        // Unanswered read: eight ACCESS cycles, then forced error completion.
        r0_req_vld = 1'b1; r0_req_addr = 32'h0000_0000; r0_req_write = 1'b0;
        tick();
        r0_req_vld = 1'b0;
        tick();
        n = 0;
        while (m_psel && m_penable && n < 40) begin
            n++;
            tick();
        end
        chk("to_cycles", 0, n, 32'd8);
        chk("to_sel", 0, {31'd0, m_psel}, 32'd0);
        chk("to_rsp", 0, {30'd0, r0_rsp_vld, r1_rsp_vld}, 32'd2);
        chk("to_err", 0, {31'd0, r0_rsp_err}, 32'd1);
        chk("to_rdata", 0, r0_rsp_rdata, 32'd0);
        tick();
`else
        n = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
